commit_trace_fifo: RTL and testbench

Capture buffer on the processor's write-back side. Each cycle it can record one (PCValue, WriteData) pair from the TopLevel core into a circular FIFO. A bench or debug port drains the FIFO through a valid/ready handshake. Overflow is counted rather than stalling the core, so the buffer never applies back-pressure to the pipeline.

---
 rtl/commit_trace_fifo.sv | 89 ++++++++
 tb/tb_commit_trace_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
// Write-back commit trace capture FIFO: records (PC, write data) pairs from the core,
// drains through a valid/ready port, and counts dropped pushes instead of stalling.
module commit_trace_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              InValid,
   input  logic [31:0]       PCValue,
   input  logic [31:0]       WriteData,
   input  logic              Freeze,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [31:0]       OutPC,
   output logic [31:0]       OutData,
   output logic [ADDR_W:0]   Count,
   output logic              Overflow,
   output logic [15:0]       DropCount
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [63:0]       mem_q [DEPTH];
   logic [ADDR_W-1:0] wp_q, wp_d;
   logic [ADDR_W-1:0] rp_q, rp_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;

   logic push, pop, full, wr_en, drop;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      push  = InValid & ~Freeze;
      pop   = (count_q != '0) & OutReady;
      full  = (count_q == FULL_CNT);
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      wr_en = push & (~full | pop);
      drop  = push & full & ~pop;

      wp_d       = wr_en ? wp_q + ADDR_W'(1) : wp_q;
      rp_d       = pop ? rp_q + ADDR_W'(1) : rp_q;
      count_d    = count_q;
      overflow_d = overflow_q | drop;
      drop_cnt_d = drop ? sat_inc16(drop_cnt_q) : drop_cnt_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is not reset; the pointers define which entries are meaningful.
   always_ff @(posedge Clk) begin
      if (Rst && wr_en) begin
         mem_q[wp_q] <= {PCValue, WriteData};
      end
   end

   always_comb begin
      OutValid  = (count_q != '0);
      OutPC     = OutValid ? mem_q[rp_q][63:32] : 32'd0;
      OutData   = OutValid ? mem_q[rp_q][31:0]  : 32'd0;
      Count     = count_q;
      Overflow  = overflow_q;
      DropCount = drop_cnt_q;
   end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Scoreboard bench for commit_trace_fifo: a queue-based reference model predicts
// occupancy, drop flags and the order of drained entries.
module tb_commit_trace_fifo;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              Clk = 1'b0;
   logic              Rst = 1'b0;
   logic              InValid = 1'b0;
   logic [31:0]       PCValue = '0;
   logic [31:0]       WriteData = '0;
   logic              Freeze = 1'b0;
   logic              OutValid;
   logic              OutReady = 1'b0;
   logic [31:0]       OutPC;
   logic [31:0]       OutData;
   logic [ADDR_W:0]   Count;
   logic              Overflow;
   logic [15:0]       DropCount;

   commit_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .Clk(Clk), .Rst(Rst), .InValid(InValid), .PCValue(PCValue), .WriteData(WriteData),
      .Freeze(Freeze), .OutValid(OutValid), .OutReady(OutReady), .OutPC(OutPC),
      .OutData(OutData), .Count(Count), .Overflow(Overflow), .DropCount(DropCount)
   );

   always #5 Clk = ~Clk;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   int          m_cnt  = 0;
   bit          m_ovf  = 1'b0;
   int          m_drop = 0;
   bit          mon_en = 1'b0;
   logic [31:0] last_pc = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; the model state is advanced just after the edge.
   task automatic step(input logic inv, input logic [31:0] pc, input logic [31:0] wd,
                       input logic frz, input logic rdy);
      bit push, pop, acc, dropped;
      int nc;
      InValid = inv; PCValue = pc; WriteData = wd; Freeze = frz; OutReady = rdy;
      push    = inv && !frz;
      pop     = (m_cnt != 0) && rdy;
      acc     = push && ((m_cnt < DEPTH) || pop);
      dropped = push && !acc;
      if (acc) exp_q.push_back({pc, wd});
      nc = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
      @(posedge Clk); #1;
      m_cnt = nc;
      if (dropped) begin
         m_ovf = 1'b1;
         if (m_drop < 65535) m_drop++;
      end
   endtask

   task automatic do_reset(input logic inv, input logic rdy);
      Rst = 1'b0; InValid = inv; OutReady = rdy; Freeze = 1'b0;
      PCValue = 32'hDEAD_0000; WriteData = 32'hBEEF_0000;
      @(posedge Clk); #1;
      Rst = 1'b1;
      m_cnt = 0; m_ovf = 1'b0; m_drop = 0;
      exp_q.delete();
      InValid = 1'b0; OutReady = 1'b0;
      chk("rst_count", 64'(Count), 64'd0);
      chk("rst_outvalid", 64'(OutValid), 64'd0);
      chk("rst_overflow", 64'(Overflow), 64'd0);
      chk("rst_dropcount", 64'(DropCount), 64'd0);
      chk("rst_outpc", 64'(OutPC), 64'd0);
      chk("rst_outdata", 64'(OutData), 64'd0);
   endtask

   // Monitor: compares state every cycle and the head entry on every handshake.
   always @(negedge Clk) begin
      if (Rst && mon_en) begin
         chk("count", 64'(Count), 64'(m_cnt));
         chk("outvalid", 64'(OutValid), 64'(m_cnt != 0));
         chk("overflow", 64'(Overflow), 64'(m_ovf));
         chk("dropcount", 64'(DropCount), 64'(m_drop));
         if (OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL head: got %0h expected nothing (scoreboard empty)", {OutPC, OutData});
            end else begin
               chk("head", {OutPC, OutData}, exp_q.pop_front());
               last_pc = OutPC;
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge Clk);
      #1;
      do_reset(1'b0, 1'b0);
      mon_en = 1'b1;

      // Three pushes, then drain them.
      step(1'b1, 32'd0, 32'd10, 1'b0, 1'b0);
      step(1'b1, 32'd4, 32'd20, 1'b0, 1'b0);
      step(1'b1, 32'd8, 32'd30, 1'b0, 1'b0);
      chk("three_count", 64'(Count), 64'd3);
      chk("three_valid", 64'(OutValid), 64'd1);
      chk("three_pc", 64'(OutPC), 64'd0);
      chk("three_data", 64'(OutData), 64'd10);
      repeat (3) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("drain3_count", 64'(Count), 64'd0);
      chk("drain3_valid", 64'(OutValid), 64'd0);
      chk("drain3_lastpc", 64'(last_pc), 64'd8);

      // Fill, overflow by 5, then push+pop at full, then drain.
      for (int i = 0; i < DEPTH + 5; i++)
         step(1'b1, 32'h1000 + 32'(i * 4), $urandom, 1'b0, 1'b0);
      chk("full_count", 64'(Count), 64'd16);
      chk("full_overflow", 64'(Overflow), 64'd1);
      chk("full_drops", 64'(DropCount), 64'd5);
      step(1'b1, 32'h100, 32'h55, 1'b0, 1'b1);
      chk("pp_full_count", 64'(Count), 64'd16);
      chk("pp_full_drops", 64'(DropCount), 64'd5);
      repeat (DEPTH) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("drain_lastpc", 64'(last_pc), 64'h100);
      chk("drain_count", 64'(Count), 64'd0);

      // Freeze suppresses pushes and drops.
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         step(1'b1, $urandom, $urandom, 1'b1, 1'($urandom_range(0, 1)));
      chk("frz_count", 64'(Count), 64'd0);
      chk("frz_overflow", 64'(Overflow), 64'd0);
      chk("frz_drops", 64'(DropCount), 64'd0);

      // Wrap-around at occupancy 2.
      step(1'b1, 32'h2000, $urandom, 1'b0, 1'b0);
      step(1'b1, 32'h2004, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++)
         step(1'b1, 32'h3000 + 32'(i * 4), $urandom, 1'b0, 1'b1);
      chk("wrap_count", 64'(Count), 64'd2);
      chk("wrap_lastpc", 64'(last_pc), 64'h3000 + 64'(37 * 4));
      repeat (2) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("wrap_final_pc", 64'(last_pc), 64'h3000 + 64'(39 * 4));

      // Random traffic including overflow and freeze phases.
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0));
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), $urandom, $urandom,
              1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0));

      // Reset mid-stream with a push and pop offered in the reset cycle.
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         step(1'b1, 32'h4000 + 32'(i), $urandom, 1'b0, 1'b0);
      chk("pre_rst_count", 64'(Count), 64'd5);
      do_reset(1'b1, 1'b1);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("post_rst_count", 64'(Count), 64'd0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
